// File: rtl/cic_decim_rt.sv
// N-stage Hogenauer CIC decimator with runtime decimation ratio, output shift and valid strobe.
// Define CIC_ROUND_SAT_EN for round-half-up plus saturation (adds one output register).
module cic_decim_rt #(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned DIFF_DELAY = 1,
  parameter int unsigned RATIO_W    = 16,
  parameter int unsigned ACC_W      = IN_W + STAGES * (RATIO_W + DIFF_DELAY - 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic        [RATIO_W-1:0]   decimation_ratio,
  input  logic        [5:0]           out_shift,
  input  logic                        in_valid,
  input  logic signed [IN_W-1:0]      d_in,
  output logic signed [OUT_W-1:0]     d_out,
  output logic                        out_valid,
  output logic                        d_clk
);

  // Pipeline slots: [0] snapshot, [1] comb input, [2..STAGES+1] comb outputs
  localparam int unsigned PIPE_N = STAGES + 2;
  localparam int unsigned LAST   = PIPE_N - 1;

  logic signed [ACC_W-1:0]   integ_q [STAGES];
  logic signed [ACC_W-1:0]   integ_d [STAGES];
  logic        [RATIO_W-1:0] cnt_q, cnt_d;
  logic        [RATIO_W-1:0] ratio_q, ratio_d;
  logic signed [ACC_W-1:0]   pipe_q [PIPE_N];
  logic signed [ACC_W-1:0]   pipe_d [PIPE_N];
  logic        [PIPE_N-1:0]  vld_q, vld_d;
  logic signed [ACC_W-1:0]   dly_q [STAGES][DIFF_DELAY];
  logic signed [ACC_W-1:0]   dly_d [STAGES][DIFF_DELAY];
  logic signed [OUT_W-1:0]   d_out_q, d_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      d_clk_q, d_clk_d;
  logic        [RATIO_W-1:0] ratio_in_c;
  logic                      dec_ev_c;

  assign ratio_in_c = (decimation_ratio == '0) ? RATIO_W'(1) : decimation_ratio;
  assign dec_ev_c   = in_valid && (cnt_q == ratio_q - RATIO_W'(1));

  // Integrators advance only on accepted samples; wrap at ACC_W is intended
  always_comb begin : integ_next
    for (int k = 0; k < STAGES; k++) integ_d[k] = integ_q[k];
    if (in_valid) begin
      integ_d[0] = integ_q[0] + ACC_W'(d_in);
      for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // Ratio reloads only at an output boundary, so periods are never cut short
  always_comb begin : count_next
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    if (in_valid) begin
      if (dec_ev_c) begin
        cnt_d   = '0;
        ratio_d = ratio_in_c;
      end else begin
        cnt_d = cnt_q + RATIO_W'(1);
      end
    end
  end

  // Comb chain: each stage and its delay line advance only with its valid token
  always_comb begin : comb_next
    vld_d = {vld_q[PIPE_N-2:0], dec_ev_c};
    for (int i = 0; i < PIPE_N; i++) pipe_d[i] = pipe_q[i];
    for (int k = 0; k < STAGES; k++)
      for (int j = 0; j < DIFF_DELAY; j++) dly_d[k][j] = dly_q[k][j];
    if (dec_ev_c) pipe_d[0] = integ_q[STAGES-1];
    if (vld_q[0]) pipe_d[1] = pipe_q[0];
    for (int k = 0; k < STAGES; k++) begin
      if (vld_q[k+1]) begin
        pipe_d[k+2] = pipe_q[k+1] - dly_q[k][DIFF_DELAY-1];
        dly_d[k][0] = pipe_q[k+1];
        for (int j = 1; j < DIFF_DELAY; j++) dly_d[k][j] = dly_q[k][j-1];
      end
    end
  end

`ifdef CIC_ROUND_SAT_EN
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] rnd_q, rnd_d, bias_c;
  logic                    rvld_q, rvld_d;

  // Round half-up in an extra bit, then clamp to the output range one clock later
  always_comb begin : out_next
    bias_c = '0;
    if (out_shift != 6'd0) bias_c = EXT_W'(1) << (out_shift - 6'd1);
    rnd_d       = rnd_q;
    rvld_d      = vld_q[LAST];
    d_out_d     = d_out_q;
    out_valid_d = rvld_q;
    d_clk_d     = out_valid_q;
    if (vld_q[LAST]) rnd_d = (EXT_W'(pipe_q[LAST]) + bias_c) >>> out_shift;
    if (rvld_q) begin
      if (rnd_q > SAT_MAX)      d_out_d = SAT_MAX[OUT_W-1:0];
      else if (rnd_q < SAT_MIN) d_out_d = SAT_MIN[OUT_W-1:0];
      else                      d_out_d = OUT_W'(rnd_q);
    end
  end

  always_ff @(posedge clk) begin : round_reg
    if (!rst_n) begin
      rnd_q  <= '0;
      rvld_q <= 1'b0;
    end else begin
      rnd_q  <= rnd_d;
      rvld_q <= rvld_d;
    end
  end
`else
  logic signed [ACC_W-1:0] shifted_c;

  // Arithmetic shift then plain truncation (wraps on overflow)
  always_comb begin : out_next
    shifted_c   = pipe_q[LAST] >>> out_shift;
    d_out_d     = d_out_q;
    out_valid_d = vld_q[LAST];
    d_clk_d     = out_valid_q;
    if (vld_q[LAST]) d_out_d = OUT_W'(shifted_c);
  end
`endif

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < DIFF_DELAY; j++) dly_q[k][j] <= '0;
      end
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
      vld_q       <= '0;
      cnt_q       <= '0;
      ratio_q     <= ratio_in_c;
      d_out_q     <= '0;
      out_valid_q <= 1'b0;
      d_clk_q     <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        for (int j = 0; j < DIFF_DELAY; j++) dly_q[k][j] <= dly_d[k][j];
      end
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= pipe_d[i];
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      d_out_q     <= d_out_d;
      out_valid_q <= out_valid_d;
      d_clk_q     <= d_clk_d;
    end
  end

  assign d_out     = d_out_q;
  assign out_valid = out_valid_q;
  assign d_clk     = d_clk_q;

endmodule

// File: tb/tb_cic_decim_rt.sv
// Directed, table-driven bench for cic_decim_rt (default parameters, either build of CIC_ROUND_SAT_EN).
module tb_cic_decim_rt;

  localparam int unsigned IN_W    = 8;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned STAGES  = 3;
  localparam int unsigned RATIO_W = 16;
`ifdef CIC_ROUND_SAT_EN
  localparam int LAT = STAGES + 3;
`else
  localparam int LAT = STAGES + 2;
`endif
  localparam int NV = 7;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic        [RATIO_W-1:0] decimation_ratio = '0;
  logic        [5:0]        out_shift = '0;
  logic                     in_valid = 1'b0;
  logic signed [IN_W-1:0]   d_in = '0;
  logic signed [OUT_W-1:0]  d_out;
  logic                     out_valid;
  logic                     d_clk;

  cic_decim_rt dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .decimation_ratio (decimation_ratio),
    .out_shift        (out_shift),
    .in_valid         (in_valid),
    .d_in             (d_in),
    .d_out            (d_out),
    .out_valid        (out_valid),
    .d_clk            (d_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ratio;
    int shift;
    int din;
    bit gapped;
    int nsamp;
    int nexp;
    int spacing;
    int ev[8];
  } vec_t;

  vec_t vecs[NV];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_edge = 1'b1;
  logic prev_ov = 1'b0;
  int   q_val[$];
  int   q_cyc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= ~rst_n;
  end

  // Output monitor: log every pulse and confirm d_clk trails out_valid by one clock
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_val.push_back(int'(d_out));
      q_cyc.push_back(cyc);
    end
    if (rst_edge === 1'b0 && (prev_ov === 1'b1 || d_clk === 1'b1))
      chk("d_clk_follows_out_valid", longint'(d_clk), longint'(prev_ov));
    prev_ov = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic apply_reset(input int ratio);
    rst_n            = 1'b0;
    in_valid         = 1'b0;
    d_in             = '0;
    decimation_ratio = RATIO_W'(ratio);
    tick();
    chk("reset_d_out", longint'(d_out), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_d_clk", longint'(d_clk), 0);
    rst_n = 1'b1;
    q_val.delete();
    q_cyc.delete();
  endtask

  // Feed n samples; ev_cyc returns the cycle of the reff-th accepted sample
  task automatic feed(input int din, input int n, input bit gap, input int reff, output int ev_cyc);
    int acc;
    acc    = 0;
    ev_cyc = -1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      d_in     = IN_W'(din);
      tick();
      acc++;
      if (acc == reff && ev_cyc < 0) ev_cyc = cyc;
      if (gap) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic int model_out(input longint v, input int sh);
    longint y;
    y = v;
`ifdef CIC_ROUND_SAT_EN
    if (sh > 0) y = y + (longint'(1) << (sh - 1));
    y = y >>> sh;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return int'(y);
`else
    y = y >>> sh;
    return int'($signed(8'(y)));
`endif
  endfunction

  initial begin
    int     ev;
    int     reff;
    int     n;
    int     exp_rc[5];
    longint big;

    // ratio, shift, d_in, gapped, samples, outputs, spacing, expected d_out
    vecs[0] = '{4, 0, 1,    1'b0, 24, 6, 4, '{1, 32, 63, 64, 64, 64, 0, 0}};
    vecs[1] = '{4, 6, -128, 1'b0, 24, 6, 4, '{-2, -64, -126, -128, -128, -128, 0, 0}};
`ifdef CIC_ROUND_SAT_EN
    vecs[2] = '{4, 5, -128, 1'b0, 24, 6, 4, '{-4, -128, -128, -128, -128, -128, 0, 0}};
    vecs[4] = '{4, 0, 127,  1'b0, 24, 6, 4, '{127, 127, 127, 127, 127, 127, 0, 0}};
    exp_rc  = '{0, 20, 60, 64, 64};
`else
    vecs[2] = '{4, 5, -128, 1'b0, 24, 6, 4, '{-4, -128, 4, 0, 0, 0, 0, 0}};
    vecs[4] = '{4, 0, 127,  1'b0, 24, 6, 4, '{127, -32, 65, -64, -64, -64, 0, 0}};
    exp_rc  = '{0, 20, 59, 64, 64};
`endif
    vecs[3] = '{4, 0, 1,    1'b1, 24, 6, 8, '{1, 32, 63, 64, 64, 64, 0, 0}};
    vecs[5] = '{0, 0, 1,    1'b0, 8,  8, 1, '{0, 0, 0, 1, 1, 1, 1, 1}};
    vecs[6] = '{2, 0, 1,    1'b0, 12, 6, 2, '{0, 1, 7, 8, 8, 8, 0, 0}};

    for (int v = 0; v < NV; v++) begin
      apply_reset(vecs[v].ratio);
      out_shift = 6'(vecs[v].shift);
      reff = (vecs[v].ratio == 0) ? 1 : vecs[v].ratio;
      feed(vecs[v].din, vecs[v].nsamp, vecs[v].gapped, reff, ev);
      idle(12);
      chk($sformatf("v%0d_pulse_count", v), q_val.size(), vecs[v].nexp);
      n = (q_val.size() < vecs[v].nexp) ? q_val.size() : vecs[v].nexp;
      for (int i = 0; i < n; i++)
        chk($sformatf("v%0d_d_out%0d", v, i), q_val[i], vecs[v].ev[i]);
      if (q_cyc.size() > 0)
        chk($sformatf("v%0d_first_latency", v), q_cyc[0] - ev, LAT);
      for (int i = 1; i < n; i++)
        chk($sformatf("v%0d_spacing%0d", v, i), q_cyc[i] - q_cyc[i-1], vecs[v].spacing);
    end

    // Ratio 4 -> 8 written mid-period: that period still ends at 4 samples
    apply_reset(4);
    out_shift = 6'd3;
    feed(1, 2, 1'b0, 4, ev);
    decimation_ratio = RATIO_W'(8);
    feed(1, 34, 1'b0, 2, ev);
    idle(12);
    chk("ratio_chg_pulse_count", q_val.size(), 5);
    n = (q_val.size() < 5) ? q_val.size() : 5;
    for (int i = 0; i < n; i++) chk($sformatf("ratio_chg_d_out%0d", i), q_val[i], exp_rc[i]);
    if (q_cyc.size() > 0) chk("ratio_chg_first_latency", q_cyc[0] - ev, LAT);
    for (int i = 1; i < n; i++) chk($sformatf("ratio_chg_spacing%0d", i), q_cyc[i] - q_cyc[i-1], 8);

    // Reset two edges after a decimation event aborts that output
    apply_reset(4);
    out_shift = 6'd0;
    feed(1, 4, 1'b0, 4, ev);
    idle(8);
    feed(1, 4, 1'b0, 4, ev);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_d_out", longint'(d_out), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_d_clk", longint'(d_clk), 0);
    rst_n = 1'b1;
    idle(12);
    chk("midrst_pulses_before", q_val.size(), 1);
    if (q_val.size() > 0) chk("midrst_first_d_out", q_val[0], 1);
    q_val.delete();
    q_cyc.delete();
    feed(1, 8, 1'b0, 4, ev);
    idle(12);
    chk("midrst_pulses_after", q_val.size(), 2);
    if (q_val.size() > 0) chk("midrst_after_d_out0", q_val[0], 1);
    if (q_val.size() > 1) chk("midrst_after_d_out1", q_val[1], 32);
    if (q_cyc.size() > 0) chk("midrst_after_latency", q_cyc[0] - ev, LAT);

    // Largest ratio: first output equals 127*C(65534,3) scaled by out_shift
    apply_reset(65535);
    out_shift = 6'd40;
    feed(127, 65535, 1'b0, 65535, ev);
    idle(12);
    big = (longint'(65534) * 65533 * 65532) / 6;
    big = big * 127;
    chk("bigR_pulse_count", q_val.size(), 1);
    if (q_val.size() > 0) chk("bigR_d_out", q_val[0], model_out(big, 40));
    if (q_cyc.size() > 0) chk("bigR_latency", q_cyc[0] - ev, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
